// File: rtl/nv_nvdla_csc_pra_cell_chn_data_out_skid_pkg.sv
// rtl/nv_nvdla_csc_pra_cell_chn_data_out_skid_pkg.sv - shared CSC constants and skid occupancy encoding
package nv_nvdla_csc_pra_cell_chn_data_out_skid_pkg;

  localparam int CSC_CHN_DW  = 256;
  localparam int CSC_BEAT_CW = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/nv_nvdla_csc_pra_cell_sat_cnt.sv
// rtl/nv_nvdla_csc_pra_cell_sat_cnt.sv - saturating clearable event counter
module nv_nvdla_csc_pra_cell_sat_cnt
  import nv_nvdla_csc_pra_cell_chn_data_out_skid_pkg::*;
#(
  parameter int CW = CSC_BEAT_CW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over a same-cycle increment; counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/nv_nvdla_csc_pra_cell_chn_data_out_skid.sv
// rtl/nv_nvdla_csc_pra_cell_chn_data_out_skid.sv - 2-entry registered skid buffer on the pra_cell chn_data_out channel
module nv_nvdla_csc_pra_cell_chn_data_out_skid
  import nv_nvdla_csc_pra_cell_chn_data_out_skid_pkg::*;
#(
  parameter int DW = CSC_CHN_DW,
  parameter int CW = CSC_BEAT_CW
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          chn_data_in_vld,
  output logic          chn_data_in_rdy,
  input  logic [DW-1:0] chn_data_in_pd,
  output logic          chn_data_out_vld,
  input  logic          chn_data_out_rdy,
  output logic [DW-1:0] chn_data_out_pd,
  input  logic          beat_cnt_clr,
  output logic [CW-1:0] beat_cnt,
  output logic          stall_flag
);

  occ_e          occ_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] skid_q;
  logic          stall_q;
  logic          push;
  logic          pop;

  // Both handshake outputs come straight from registered occupancy.
  assign chn_data_in_rdy  = (occ_q != OCC_FULL);
  assign chn_data_out_vld = (occ_q != OCC_EMPTY);
  assign chn_data_out_pd  = head_q;
  assign stall_flag       = stall_q;

  assign push = chn_data_in_vld & chn_data_in_rdy;
  assign pop  = chn_data_out_vld & chn_data_out_rdy;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      occ_q   <= OCC_EMPTY;
      stall_q <= 1'b0;
    end else begin
      stall_q <= chn_data_out_vld & ~chn_data_out_rdy;
      case (occ_q)
        OCC_EMPTY: if (push) occ_q <= OCC_ONE;
        OCC_ONE: begin
          if (push && !pop) begin
            occ_q <= OCC_FULL;
          end else if (pop && !push) begin
            occ_q <= OCC_EMPTY;
          end
        end
        OCC_FULL:  if (pop) occ_q <= OCC_ONE;
        default:   occ_q <= OCC_EMPTY;
      endcase
    end
  end

  // head_q always holds the oldest beat; skid_q only fills when head is blocked.
  always_ff @(posedge nvdla_core_clk) begin
    if (push && ((occ_q == OCC_EMPTY) || ((occ_q == OCC_ONE) && pop))) begin
      head_q <= chn_data_in_pd;
    end else if (pop && (occ_q == OCC_FULL)) begin
      head_q <= skid_q;
    end
    if (push && (occ_q == OCC_ONE) && !pop) begin
      skid_q <= chn_data_in_pd;
    end
  end

  nv_nvdla_csc_pra_cell_sat_cnt #(
    .CW (CW)
  ) u_beat_cnt (
    .clk_i (nvdla_core_clk),
    .rst_i (nvdla_core_rst),
    .clr_i (beat_cnt_clr),
    .inc_i (pop),
    .cnt_o (beat_cnt)
  );

endmodule

// File: tb/tb_nv_nvdla_csc_pra_cell_chn_data_out_skid.sv
// tb/tb_nv_nvdla_csc_pra_cell_chn_data_out_skid.sv - directed bench for the chn_data_out skid buffer
module tb_nv_nvdla_csc_pra_cell_chn_data_out_skid;

  logic         clk;
  logic         rst;
  logic         in_vld;
  logic         in_rdy;
  logic [255:0] in_pd;
  logic         out_vld;
  logic         out_rdy;
  logic [255:0] out_pd;
  logic         clr;
  logic [15:0]  beat_cnt;
  logic         stall;

  logic         in_rdy4;
  logic         out_vld4;
  logic [7:0]   out_pd4;
  logic [3:0]   beat_cnt4;
  logic         stall4;

  int n_vec;
  int n_err;

  nv_nvdla_csc_pra_cell_chn_data_out_skid dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .chn_data_in_vld  (in_vld),
    .chn_data_in_rdy  (in_rdy),
    .chn_data_in_pd   (in_pd),
    .chn_data_out_vld (out_vld),
    .chn_data_out_rdy (out_rdy),
    .chn_data_out_pd  (out_pd),
    .beat_cnt_clr     (clr),
    .beat_cnt         (beat_cnt),
    .stall_flag       (stall)
  );

  nv_nvdla_csc_pra_cell_chn_data_out_skid #(
    .DW (8),
    .CW (4)
  ) dut_cw4 (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .chn_data_in_vld  (in_vld),
    .chn_data_in_rdy  (in_rdy4),
    .chn_data_in_pd   (in_pd[7:0]),
    .chn_data_out_vld (out_vld4),
    .chn_data_out_rdy (out_rdy),
    .chn_data_out_pd  (out_pd4),
    .beat_cnt_clr     (clr),
    .beat_cnt         (beat_cnt4),
    .stall_flag       (stall4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] PD_A5 = {32{8'hA5}};
  localparam logic [255:0] PD_B1 = {32{8'hB1}};
  localparam logic [255:0] PD_B2 = {32{8'hB2}};
  localparam logic [255:0] PD_B3 = {32{8'hB3}};
  localparam logic [255:0] PD_C1 = {32{8'hC1}};
  localparam logic [255:0] PD_C2 = {32{8'hC2}};
  localparam logic [255:0] PD_E1 = {32{8'hE1}};

  initial begin
    int exp_idx;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_pd   = '0;
    out_rdy = 1'b0;
    clr     = 1'b0;
    step;
    step;
    rst = 1'b0;

    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_stall", stall, 0);

    // single beat: one-cycle latency, no bypass
    in_vld = 1'b1; in_pd = PD_A5; out_rdy = 1'b1;
    chk("lat_no_bypass", out_vld, 0);
    step;
    in_vld = 1'b0; in_pd = '0;
    chk("lat_out_vld", out_vld, 1);
    chk("lat_out_pd", out_pd, PD_A5);
    chk("lat_cnt_pre", beat_cnt, 0);
    step;
    chk("lat_cnt", beat_cnt, 1);
    chk("lat_empty", out_vld, 0);
    chk("lat_stall", stall, 0);

    // back-pressure: third beat held off while FULL
    out_rdy = 1'b0;
    in_vld = 1'b1; in_pd = PD_B1;
    step;
    chk("bp_rdy1", in_rdy, 1);
    chk("bp_pd1", out_pd, PD_B1);
    chk("bp_stall1", stall, 0);
    in_pd = PD_B2;
    step;
    chk("bp_rdy2", in_rdy, 0);
    chk("bp_pd2", out_pd, PD_B1);
    chk("bp_stall2", stall, 1);
    in_pd = PD_B3;
    step;
    chk("bp_rdy3", in_rdy, 0);
    chk("bp_pd3", out_pd, PD_B1);
    chk("bp_vld3", out_vld, 1);
    chk("bp_stall3", stall, 1);
    chk("bp_cnt3", beat_cnt, 1);

    // drain from FULL with input still offered
    out_rdy = 1'b1;
    step;
    chk("dr_pd_b2", out_pd, PD_B2);
    chk("dr_rdy", in_rdy, 1);
    chk("dr_cnt2", beat_cnt, 2);
    step;
    in_vld = 1'b0;
    chk("dr_pd_b3", out_pd, PD_B3);
    chk("dr_cnt3", beat_cnt, 3);
    step;
    chk("dr_empty", out_vld, 0);
    chk("dr_cnt4", beat_cnt, 4);
    chk("dr_stall", stall, 0);

    // 1000 beats at full throughput
    rst = 1'b1;
    step;
    rst = 1'b0;
    exp_idx = 0;
    out_rdy = 1'b1;
    for (int cyc = 0; cyc <= 1000; cyc++) begin
      in_vld = (cyc < 1000);
      in_pd  = 256'(cyc);
      if (out_vld) begin
        chk("tp_pd", out_pd, 256'(exp_idx));
        exp_idx++;
      end
      step;
    end
    in_vld = 1'b0;
    chk("tp_pops", exp_idx, 1000);
    chk("tp_cnt", beat_cnt, 1000);
    chk("tp_cnt4_sat", beat_cnt4, 15);
    chk("tp_empty", out_vld, 0);

    // clear beats a simultaneous pop
    out_rdy = 1'b0;
    in_vld = 1'b1; in_pd = PD_A5;
    step;
    in_vld = 1'b0;
    chk("clr_cnt_hold", beat_cnt, 1000);
    chk("clr_cnt4_hold", beat_cnt4, 15);
    out_rdy = 1'b1; clr = 1'b1;
    step;
    clr = 1'b0;
    chk("clr_cnt", beat_cnt, 0);
    chk("clr_cnt4", beat_cnt4, 0);
    chk("clr_popped", out_vld, 0);

    // reset while FULL discards contents and ignores handshakes
    out_rdy = 1'b0;
    in_vld = 1'b1; in_pd = PD_C1;
    step;
    in_pd = PD_C2;
    step;
    chk("rf_full", in_rdy, 0);
    rst = 1'b1; out_rdy = 1'b1; in_pd = PD_E1;
    step;
    rst = 1'b0; in_vld = 1'b0;
    chk("rf_out_vld", out_vld, 0);
    chk("rf_in_rdy", in_rdy, 1);
    chk("rf_cnt", beat_cnt, 0);
    chk("rf_stall", stall, 0);
    step;
    step;
    chk("rf_no_stale", out_vld, 0);
    in_vld = 1'b1; in_pd = PD_E1;
    step;
    in_vld = 1'b0;
    chk("rf_fresh_pd", out_pd, PD_E1);
    step;
    chk("rf_fresh_cnt", beat_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_csc_pra_cell_chn_data_out_skid.md
NV_NVDLA_CSC_PRA_CELL_CHN_DATA_OUT_SKID -- requirements
Module: nv_nvdla_csc_pra_cell_chn_data_out_skid

Interface
REQ-001 SHALL have parameter DW, default 256, payload width of one chn_data_out beat.
REQ-002 SHALL have parameter CW, default 16, width of the beat counter.
REQ-003 SHALL have port nvdla_core_clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port nvdla_core_rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port chn_data_in_vld  input  1  upstream (pra_cell core output channel) beat valid.
REQ-006 SHALL have port chn_data_in_rdy  output  1  block can accept a beat this cycle.
REQ-007 SHALL have port chn_data_in_pd  input  DW  upstream payload.
REQ-008 SHALL have port chn_data_out_vld  output  1  downstream beat valid.
REQ-009 SHALL have port chn_data_out_rdy  input  1  downstream accepts the beat.
REQ-010 SHALL have port chn_data_out_pd  output  DW  downstream payload.
REQ-011 SHALL have port beat_cnt_clr  input  1  clear beat counter.
REQ-012 SHALL have port beat_cnt  output  CW  count of beats delivered downstream.
REQ-013 SHALL have port stall_flag  output  1  registered flag: downstream back-pressure held last cycle.

Function
REQ-014 SHALL implement a 2-entry in-order skid buffer; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-015 SHALL define push = chn_data_in_vld & chn_data_in_rdy and pop = chn_data_out_vld & chn_data_out_rdy.
REQ-016 SHALL drive chn_data_in_rdy solely from registered state: 1 when not FULL, 0 when FULL; no combinational path from chn_data_out_rdy.
REQ-017 SHALL drive chn_data_out_vld = 1 iff occupancy != EMPTY; chn_data_out_pd = oldest stored entry.
REQ-018 SHALL provide 1-cycle latency: beat pushed in cycle N is presented at output in cycle N+1 when buffer was EMPTY; no input-to-output bypass.
REQ-019 SHALL transition: EMPTY--push-->ONE; ONE--push&!pop-->FULL; ONE--pop&!push-->EMPTY; ONE--push&pop-->ONE; FULL--pop-->ONE; otherwise hold.
REQ-020 SHALL sustain one beat per cycle in state ONE under continuous push and pop.
REQ-021 SHALL hold chn_data_out_pd and chn_data_out_vld stable while chn_data_out_vld & !chn_data_out_rdy.
REQ-022 SHALL ignore chn_data_in_pd when push is 0; stored entries never overwritten before popped.
REQ-023 SHALL increment beat_cnt by 1 on each pop, saturating at 2^CW-1 (no wrap).
REQ-024 SHALL give beat_cnt_clr priority: clr and pop in same cycle yields beat_cnt = 0.
REQ-025 SHALL register stall_flag = chn_data_out_vld & !chn_data_out_rdy, updated every cycle.

Reset
REQ-026 SHALL on nvdla_core_rst=1 at a clock edge set occupancy EMPTY, beat_cnt 0, stall_flag 0, chn_data_out_vld 0, chn_data_in_rdy 1 from the following cycle.
REQ-027 SHALL discard buffered beats when reset asserts mid-operation; payload registers need not be reset.
REQ-028 SHALL ignore chn_data_in_vld, chn_data_out_rdy and beat_cnt_clr during reset cycles.

Structure
REQ-029 SHALL place occupancy-state encoding (2-bit EMPTY/ONE/FULL) and default DW/CW constants in the shared CSC package.
REQ-030 SHALL instantiate one sub-module nv_nvdla_csc_pra_cell_sat_cnt for the saturating clearable beat counter; the skid datapath stays in the top module.

Verification
REQ-031 SHALL cover: reset, then in_vld=1 pd=0xA5.., out_rdy=1 -> out_vld=1 with pd=0xA5.. exactly one cycle later, beat_cnt=1.
REQ-032 SHALL cover: out_rdy=0, push 3 beats on consecutive cycles -> first two accepted, in_rdy=0 from cycle 2, third held; out_pd stays beat 1; stall_flag=1.
REQ-033 SHALL cover: FULL, out_rdy=1 and in_vld=1 together -> pop occurs, no push that cycle, next cycle ONE then push accepted; order 1,2,3 preserved.
REQ-034 SHALL cover: 1000 beats, in_vld and out_rdy both constantly 1 -> 1000 pops in 1001 cycles, beat_cnt=1000.
REQ-035 SHALL cover: CW=4, 20 pops -> beat_cnt saturates at 15; beat_cnt_clr with simultaneous pop -> 0.
REQ-036 SHALL cover: reset asserted while FULL -> next cycle out_vld=0, in_rdy=1, beat_cnt=0; stale beats never appear.
